// File: rtl/mem_stage.sv
// RV64 memory-access stage: passes ALU results through in one cycle and runs
// loads/stores on the data-memory port, stalling EX while busy.
module mem_stage #(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] ZERO_WORD = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_req_we,
    output logic [XLEN-1:0] dmem_req_addr,
    output logic [XLEN-1:0] dmem_req_wdata,
    output logic [7:0]      dmem_req_wmask,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_resp_rdata,
    output logic [XLEN-1:0] m_data,
    output logic            m_ena,
    output logic [4:0]      m_addr,
    output logic            wb_signal,
    output logic            misalign_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_wmask;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic            r_reg_we;

    logic            w_fire;
    logic            w_is_mem;
    logic            w_misalign;
    logic [7:0]      w_st_mask;
    logic [XLEN-1:0] w_st_data;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_ld_data;

    assign ex_ready       = (r_state == IDLE);
    assign w_fire         = ex_valid && ex_ready;
    assign w_is_mem       = ex_mem_read || ex_mem_write;
    assign dmem_req_valid = (r_state == REQ);
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = {r_addr[XLEN-1:3], 3'b000};
    assign dmem_req_wdata = r_wdata;
    assign dmem_req_wmask = r_wmask;
    assign w_st_data      = ex_wdata << {ex_addr[2:0], 3'b000};
    assign w_lane         = dmem_resp_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        w_misalign = 1'b0;
        w_st_mask  = 8'hFF;
        unique case (ex_funct3[1:0])
            2'b00: begin
                w_misalign = 1'b0;
                w_st_mask  = 8'h01 << ex_addr[2:0];
            end
            2'b01: begin
                w_misalign = ex_addr[0];
                w_st_mask  = 8'h03 << ex_addr[2:0];
            end
            2'b10: begin
                w_misalign = |ex_addr[1:0];
                w_st_mask  = 8'h0F << ex_addr[2:0];
            end
            2'b11: begin
                w_misalign = |ex_addr[2:0];
                w_st_mask  = 8'hFF;
            end
        endcase
    end

    always_comb begin
        w_ld_data = w_lane;
        case (r_funct3)
            3'b000:  w_ld_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ld_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_ld_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            3'b110:  w_ld_data = {{(XLEN-32){1'b0}}, w_lane[31:0]};
            default: w_ld_data = w_lane;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_fire && w_is_mem && !w_misalign) w_next = REQ;
            REQ:     if (dmem_req_ready) w_next = r_we ? IDLE : WAIT;
            WAIT:    if (dmem_resp_valid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Request fields stay frozen from acceptance until the next transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wmask  <= 8'h00;
            r_funct3 <= 3'b000;
            r_rd     <= 5'd0;
            r_reg_we <= 1'b0;
        end else if (w_fire && w_is_mem && !w_misalign) begin
            r_we     <= ex_mem_write;
            r_addr   <= ex_addr;
            r_wdata  <= w_st_data;
            r_wmask  <= ex_mem_write ? w_st_mask : 8'h00;
            r_funct3 <= ex_funct3;
            r_rd     <= ex_rd;
            r_reg_we <= ex_reg_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data       <= ZERO_WORD;
            m_ena        <= 1'b0;
            m_addr       <= 5'd0;
            wb_signal    <= 1'b1;
            misalign_err <= 1'b0;
        end else begin
            m_ena        <= 1'b0;
            wb_signal    <= 1'b1;
            misalign_err <= 1'b0;
            if (w_fire && !w_is_mem) begin
                m_data    <= ex_alu_res;
                m_ena     <= ex_reg_we && (ex_rd != 5'd0);
                m_addr    <= ex_rd;
                wb_signal <= 1'b0;
            end else if (w_fire && w_misalign) begin
                misalign_err <= 1'b1;
            end else if (r_state == WAIT && dmem_resp_valid) begin
                m_data    <= w_ld_data;
                m_ena     <= r_reg_we && (r_rd != 5'd0);
                m_addr    <= r_rd;
                wb_signal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment
// and mid-operation reset, all against hand-computed values.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [63:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [63:0] ex_alu_res;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [63:0] dmem_req_addr;
    logic [63:0] dmem_req_wdata;
    logic [7:0]  dmem_req_wmask;
    logic        dmem_resp_valid;
    logic [63:0] dmem_resp_rdata;
    logic [63:0] m_data;
    logic        m_ena;
    logic [4:0]  m_addr;
    logic        wb_signal;
    logic        misalign_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_funct3       (ex_funct3),
        .ex_addr         (ex_addr),
        .ex_wdata        (ex_wdata),
        .ex_alu_res      (ex_alu_res),
        .ex_rd           (ex_rd),
        .ex_reg_we       (ex_reg_we),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_req_we     (dmem_req_we),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_wdata  (dmem_req_wdata),
        .dmem_req_wmask  (dmem_req_wmask),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_resp_rdata (dmem_resp_rdata),
        .m_data          (m_data),
        .m_ena           (m_ena),
        .m_addr          (m_addr),
        .wb_signal       (wb_signal),
        .misalign_err    (misalign_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        ex_funct3    = 3'd0;
        ex_addr      = 64'h0;
        ex_wdata     = 64'h0;
        ex_alu_res   = 64'h0;
        ex_rd        = 5'd0;
        ex_reg_we    = 1'b0;
    endtask

    task automatic send(input logic rd_op, input logic wr_op,
                        input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd, input logic [63:0] alu,
                        input logic [4:0] rd, input logic we);
        ex_valid     = 1'b1;
        ex_mem_read  = rd_op;
        ex_mem_write = wr_op;
        ex_funct3    = f3;
        ex_addr      = addr;
        ex_wdata     = wd;
        ex_alu_res   = alu;
        ex_rd        = rd;
        ex_reg_we    = we;
        tick();
        idle_in();
        ex_addr  = 64'hDEAD_BEEF_DEAD_BEEF;
        ex_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    initial begin
        idle_in();
        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 64'h0;
        tick();
        tick();
        chk("rst_m_data", m_data, 64'h0);
        chk("rst_m_ena", {63'h0, m_ena}, 64'h0);
        chk("rst_m_addr", {59'h0, m_addr}, 64'h0);
        chk("rst_wb", {63'h0, wb_signal}, 64'h1);
        chk("rst_reqv", {63'h0, dmem_req_valid}, 64'h0);
        chk("rst_mis", {63'h0, misalign_err}, 64'h0);
        chk("rst_rdy", {63'h0, ex_ready}, 64'h1);
        rst = 1'b0;
        tick();

        // ADD pass-through
        send(0, 0, 3'd0, 64'h0, 64'h0, 64'h1234, 5'd5, 1);
        chk("add_data", m_data, 64'h1234);
        chk("add_ena", {63'h0, m_ena}, 64'h1);
        chk("add_addr", {59'h0, m_addr}, 64'd5);
        chk("add_wb", {63'h0, wb_signal}, 64'h0);
        tick();
        chk("add_ena_1cyc", {63'h0, m_ena}, 64'h0);
        chk("add_wb_1cyc", {63'h0, wb_signal}, 64'h1);
        chk("add_hold", m_data, 64'h1234);

        // LB with delayed request acceptance
        send(1, 0, 3'b000, 64'h1003, 64'h0, 64'h0, 5'd7, 1);
        chk("lb_rdy0", {63'h0, ex_ready}, 64'h0);
        chk("lb_reqv", {63'h0, dmem_req_valid}, 64'h1);
        chk("lb_addr", dmem_req_addr, 64'h1000);
        chk("lb_we", {63'h0, dmem_req_we}, 64'h0);
        tick();
        chk("lb_reqv_hold", {63'h0, dmem_req_valid}, 64'h1);
        chk("lb_addr_hold", dmem_req_addr, 64'h1000);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("lb_reqv_off", {63'h0, dmem_req_valid}, 64'h0);
        chk("lb_rdy_wait", {63'h0, ex_ready}, 64'h0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h0000_0000_8000_0000;
        tick();
        dmem_resp_valid = 1'b0;
        chk("lb_data", m_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_ena", {63'h0, m_ena}, 64'h1);
        chk("lb_maddr", {59'h0, m_addr}, 64'd7);
        chk("lb_wb", {63'h0, wb_signal}, 64'h0);
        chk("lb_rdy1", {63'h0, ex_ready}, 64'h1);

        // LWU, one response wait cycle
        send(1, 0, 3'b110, 64'h2004, 64'h0, 64'h0, 5'd9, 1);
        chk("lwu_rdy_req", {63'h0, ex_ready}, 64'h0);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("lwu_rdy_w1", {63'h0, ex_ready}, 64'h0);
        tick();
        chk("lwu_rdy_w2", {63'h0, ex_ready}, 64'h0);
        chk("lwu_no_wb", {63'h0, m_ena}, 64'h0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h89AB_CDEF_0000_0000;
        tick();
        dmem_resp_valid = 1'b0;
        chk("lwu_data", m_data, 64'h0000_0000_89AB_CDEF);
        chk("lwu_ena", {63'h0, m_ena}, 64'h1);

        // SH upper lanes
        send(0, 1, 3'b001, 64'h3006, 64'hBEEF, 64'h0, 5'd0, 0);
        chk("sh_reqv", {63'h0, dmem_req_valid}, 64'h1);
        chk("sh_we", {63'h0, dmem_req_we}, 64'h1);
        chk("sh_mask", {56'h0, dmem_req_wmask}, 64'hC0);
        chk("sh_wdata", dmem_req_wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_addr", dmem_req_addr, 64'h3000);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("sh_ena", {63'h0, m_ena}, 64'h0);
        chk("sh_wb", {63'h0, wb_signal}, 64'h1);
        chk("sh_idle", {63'h0, ex_ready}, 64'h1);

        // SW in upper word
        send(0, 1, 3'b010, 64'h5004, 64'hDEAD_BEEF, 64'h0, 5'd0, 0);
        chk("sw_mask", {56'h0, dmem_req_wmask}, 64'hF0);
        chk("sw_wdata", dmem_req_wdata, 64'hDEAD_BEEF_0000_0000);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;

        // Misaligned LW
        send(1, 0, 3'b010, 64'h4002, 64'h0, 64'h0, 5'd3, 1);
        chk("mis_err", {63'h0, misalign_err}, 64'h1);
        chk("mis_ena", {63'h0, m_ena}, 64'h0);
        chk("mis_wb", {63'h0, wb_signal}, 64'h1);
        chk("mis_noreq", {63'h0, dmem_req_valid}, 64'h0);
        tick();
        chk("mis_1cyc", {63'h0, misalign_err}, 64'h0);
        chk("mis_noreq2", {63'h0, dmem_req_valid}, 64'h0);

        // LH to x0: load issues, no register write
        send(1, 0, 3'b001, 64'h7002, 64'h0, 64'h0, 5'd0, 1);
        chk("x0_reqv", {63'h0, dmem_req_valid}, 64'h1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h0000_0000_8001_0000;
        tick();
        dmem_resp_valid = 1'b0;
        chk("x0_data", m_data, 64'hFFFF_FFFF_FFFF_8001);
        chk("x0_ena", {63'h0, m_ena}, 64'h0);
        chk("x0_wb", {63'h0, wb_signal}, 64'h0);

        // Reset while waiting for a response
        send(1, 0, 3'b011, 64'h8000, 64'h0, 64'h0, 5'd3, 1);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        chk("mr_wait", {63'h0, ex_ready}, 64'h0);
        rst = 1'b1;
        #1;
        chk("mr_rdy", {63'h0, ex_ready}, 64'h1);
        chk("mr_data", m_data, 64'h0);
        chk("mr_wb", {63'h0, wb_signal}, 64'h1);
        tick();
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'h1111_2222_3333_4444;
        tick();
        dmem_resp_valid = 1'b0;
        chk("mr_ign_ena", {63'h0, m_ena}, 64'h0);
        chk("mr_ign_data", m_data, 64'h0);
        chk("mr_ign_wb", {63'h0, wb_signal}, 64'h1);
        send(0, 0, 3'd0, 64'h0, 64'h0, 64'h55, 5'd2, 1);
        chk("mr_add_data", m_data, 64'h55);
        chk("mr_add_ena", {63'h0, m_ena}, 64'h1);
        chk("mr_add_addr", {59'h0, m_addr}, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
